// File: rtl/eth_frame_tx.sv
// Ethernet frame serializer: takes one header (dest MAC, src MAC, EtherType)
// and an 8-bit payload stream. It emits the 14 header bytes, then the payload,
// then optional zero padding up to MIN_FRAME_LEN, on a single byte stream.
//
// Handshake rule (all three interfaces): a beat transfers on a rising clk edge
// where valid && ready are both high. A source holds valid and its data stable
// until that transfer. The output side never drops a valid beat, and never
// changes a valid beat, while it waits for ready.
module eth_frame_tx #(
    parameter int ENABLE_PADDING = 0,
    parameter int MIN_FRAME_LEN  = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_eth_hdr_valid,
    output logic        s_eth_hdr_ready,
    input  logic [47:0] s_eth_dest_mac,
    input  logic [47:0] s_eth_src_mac,
    input  logic [15:0] s_eth_type,
    input  logic [7:0]  s_eth_payload_axis_tdata,
    input  logic        s_eth_payload_axis_tvalid,
    output logic        s_eth_payload_axis_tready,
    input  logic        s_eth_payload_axis_tlast,
    input  logic        s_eth_payload_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_PAD     = 2'd3
    } state_t;

    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] HDR_LAST = 16'd13;

    // FSM state, kept as a named enum so checkers can bind to it
    state_t      state;
    state_t      state_next;

    logic [47:0] dest_q;
    logic [47:0] src_q;
    logic [15:0] type_q;
    logic [15:0] count_q;
    logic [15:0] count_inc;
    logic        user_q;
    logic [7:0]  hdr_byte;
    logic        out_en;
    logic        hdr_fire;
    logic        pay_fire;
    logic        pad_needed;
    logic        pad_done;

    // The output register may take a new beat when empty or being drained
    assign out_en     = !m_axis_tvalid || m_axis_tready;
    assign count_inc  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    assign hdr_fire   = s_eth_hdr_valid && s_eth_hdr_ready;
    assign pay_fire   = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
    assign pad_needed = (ENABLE_PADDING != 0) && (count_inc < MIN_LEN);
    assign pad_done   = (count_inc >= MIN_LEN);

    // Pick the header byte for the current emitted-byte index (MSB first)
    always_comb begin
        hdr_byte = 8'h00;
        case (count_q[3:0])
            4'd0:    hdr_byte = dest_q[47:40];
            4'd1:    hdr_byte = dest_q[39:32];
            4'd2:    hdr_byte = dest_q[31:24];
            4'd3:    hdr_byte = dest_q[23:16];
            4'd4:    hdr_byte = dest_q[15:8];
            4'd5:    hdr_byte = dest_q[7:0];
            4'd6:    hdr_byte = src_q[47:40];
            4'd7:    hdr_byte = src_q[39:32];
            4'd8:    hdr_byte = src_q[31:24];
            4'd9:    hdr_byte = src_q[23:16];
            4'd10:   hdr_byte = src_q[15:8];
            4'd11:   hdr_byte = src_q[7:0];
            4'd12:   hdr_byte = type_q[15:8];
            4'd13:   hdr_byte = type_q[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (hdr_fire) begin
                    state_next = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (out_en && count_q == HDR_LAST) begin
                    state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (pay_fire && s_eth_payload_axis_tlast) begin
                    state_next = pad_needed ? ST_PAD : ST_IDLE;
                end
            end
            ST_PAD: begin
                if (out_en && pad_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake readies and busy, all forced low while reset is asserted
    always_comb begin
        s_eth_hdr_ready           = !rst && (state == ST_IDLE);
        s_eth_payload_axis_tready = !rst && (state == ST_PAYLOAD) && out_en;
        busy                      = !rst && (state != ST_IDLE);
    end

    // Header latch, byte counter and the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            dest_q        <= '0;
            src_q         <= '0;
            type_q        <= '0;
            count_q       <= '0;
            user_q        <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else begin
            if (hdr_fire) begin
                dest_q  <= s_eth_dest_mac;
                src_q   <= s_eth_src_mac;
                type_q  <= s_eth_type;
                count_q <= '0;
                user_q  <= 1'b0;
            end
            case (state)
                ST_HEADER: begin
                    if (out_en) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= hdr_byte;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tuser  <= 1'b0;
                        count_q       <= count_inc;
                    end
                end
                ST_PAYLOAD: begin
                    if (pay_fire) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= s_eth_payload_axis_tdata;
                        count_q       <= count_inc;
                        // tlast/tuser are only forwarded when no padding follows
                        if (s_eth_payload_axis_tlast && !pad_needed) begin
                            m_axis_tlast <= 1'b1;
                            m_axis_tuser <= s_eth_payload_axis_tuser;
                        end else begin
                            m_axis_tlast <= 1'b0;
                            m_axis_tuser <= 1'b0;
                        end
                        if (s_eth_payload_axis_tlast) begin
                            user_q <= s_eth_payload_axis_tuser;
                        end
                    end else if (out_en) begin
                        m_axis_tvalid <= 1'b0;
                    end
                end
                ST_PAD: begin
                    if (out_en) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= 8'h00;
                        m_axis_tlast  <= pad_done;
                        m_axis_tuser  <= pad_done && user_q;
                        count_q       <= count_inc;
                    end
                end
                default: begin
                    if (out_en) begin
                        m_axis_tvalid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Bench for eth_frame_tx: one instance without padding, one with padding
// (MIN_FRAME_LEN 60), selected by use_pad. A behavioural model turns each
// header + payload into the expected byte list.
module tb_eth_frame_tx;

    localparam int MIN_LEN = 60;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // shared stimulus
    logic        hdr_valid;
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] etype;
    logic [7:0]  p_tdata;
    logic        p_tvalid;
    logic        p_tlast;
    logic        p_tuser;
    logic        m_tready;
    logic        use_pad;

    // per-instance outputs
    logic       hdr_ready_n, hdr_ready_p, p_tready_n, p_tready_p;
    logic [7:0] m_tdata_n, m_tdata_p;
    logic       m_tvalid_n, m_tvalid_p, m_tlast_n, m_tlast_p;
    logic       m_tuser_n, m_tuser_p, busy_n, busy_p;

    // selected-instance view
    logic       hdr_ready, p_tready, m_tvalid, m_tlast, m_tuser, busy;
    logic [7:0] m_tdata;
    assign hdr_ready = use_pad ? hdr_ready_p : hdr_ready_n;
    assign p_tready  = use_pad ? p_tready_p  : p_tready_n;
    assign m_tdata   = use_pad ? m_tdata_p   : m_tdata_n;
    assign m_tvalid  = use_pad ? m_tvalid_p  : m_tvalid_n;
    assign m_tlast   = use_pad ? m_tlast_p   : m_tlast_n;
    assign m_tuser   = use_pad ? m_tuser_p   : m_tuser_n;
    assign busy      = use_pad ? busy_p      : busy_n;

    eth_frame_tx #(.ENABLE_PADDING(0), .MIN_FRAME_LEN(MIN_LEN)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .s_eth_hdr_valid           (hdr_valid && !use_pad),
        .s_eth_hdr_ready           (hdr_ready_n),
        .s_eth_dest_mac            (dest),
        .s_eth_src_mac             (src),
        .s_eth_type                (etype),
        .s_eth_payload_axis_tdata  (p_tdata),
        .s_eth_payload_axis_tvalid (p_tvalid && !use_pad),
        .s_eth_payload_axis_tready (p_tready_n),
        .s_eth_payload_axis_tlast  (p_tlast),
        .s_eth_payload_axis_tuser  (p_tuser),
        .m_axis_tdata              (m_tdata_n),
        .m_axis_tvalid             (m_tvalid_n),
        .m_axis_tready             (m_tready),
        .m_axis_tlast              (m_tlast_n),
        .m_axis_tuser              (m_tuser_n),
        .busy                      (busy_n)
    );

    eth_frame_tx #(.ENABLE_PADDING(1), .MIN_FRAME_LEN(MIN_LEN)) dut_pad (
        .clk                       (clk),
        .rst                       (rst),
        .s_eth_hdr_valid           (hdr_valid && use_pad),
        .s_eth_hdr_ready           (hdr_ready_p),
        .s_eth_dest_mac            (dest),
        .s_eth_src_mac             (src),
        .s_eth_type                (etype),
        .s_eth_payload_axis_tdata  (p_tdata),
        .s_eth_payload_axis_tvalid (p_tvalid && use_pad),
        .s_eth_payload_axis_tready (p_tready_p),
        .s_eth_payload_axis_tlast  (p_tlast),
        .s_eth_payload_axis_tuser  (p_tuser),
        .m_axis_tdata              (m_tdata_p),
        .m_axis_tvalid             (m_tvalid_p),
        .m_axis_tready             (m_tready),
        .m_axis_tlast              (m_tlast_p),
        .m_axis_tuser              (m_tuser_p),
        .busy                      (busy_p)
    );

    // scoreboard state
    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_q[$];
    logic [9:0] exp_beat;
    bit         sb_on = 1'b0;
    int         beats = 0;
    int         tlast_seen = 0;
    int         first_cyc = 0;
    int         last_cyc = 0;
    logic       last_user = 1'b0;
    bit         stall_prev = 1'b0;
    logic [9:0] stall_beat = '0;

    // stimulus controls
    int         rmode = 0;
    bit         gap_en = 1'b0;
    logic [7:0] pl_data[256];
    logic       pl_user[256];
    int         pl_len = 0;
    int         t_last, t_hdr, t_first, nwait;

    typedef struct {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] etype;
        logic [7:0]  first;
        int          plen;
        int          user_at;
        int          rmode;
        bit          pad;
        int          exp_beats;
        logic        exp_user;
    } vec_t;
    vec_t vt[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // downstream ready pattern: 0 always ready, 1 toggling, 2 random
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       m_tready = 1'b1;
                1:       m_tready = !m_tready;
                default: m_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // output monitor: stall stability and beat-by-beat scoreboard
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!m_tvalid || {m_tuser, m_tlast, m_tdata} !== stall_beat) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b beat=0x%0h expected valid=1 beat=0x%0h",
                             m_tvalid, {m_tuser, m_tlast, m_tdata}, stall_beat);
                end
            end
            stall_prev = m_tvalid && !m_tready;
            stall_beat = {m_tuser, m_tlast, m_tdata};
            if (m_tvalid && m_tready) begin
                if (beats == 0) first_cyc = cyc;
                last_cyc  = cyc;
                last_user = m_tuser;
                beats++;
                if (m_tlast) tlast_seen++;
                if (sb_on) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat_extra: got 0x%0h expected no beat", {m_tuser, m_tlast, m_tdata});
                    end else begin
                        exp_beat = exp_q.pop_front();
                        if ({m_tuser, m_tlast, m_tdata} !== exp_beat) begin
                            errors++;
                            $display("FAIL beat_%0d: got 0x%0h expected 0x%0h",
                                     beats, {m_tuser, m_tlast, m_tdata}, exp_beat);
                        end
                    end
                    if (!m_tlast) begin
                        checks++;
                        if (busy !== 1'b1) begin
                            errors++;
                            $display("FAIL busy_mid: got %0b expected 1", busy);
                        end
                    end
                end
            end
        end
    end

    // reference model: header bytes MSB first, payload, zero fill to MIN_LEN
    task automatic model_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t, input bit pad);
        logic [111:0] h;
        logic [7:0]   bytes[$];
        int           n;
        h = {d, s, t};
        for (int i = 0; i < 14; i++) bytes.push_back(h[111 - 8 * i -: 8]);
        for (int i = 0; i < pl_len; i++) bytes.push_back(pl_data[i]);
        if (pad) while (bytes.size() < MIN_LEN) bytes.push_back(8'h00);
        n = bytes.size();
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == n - 1) ? pl_user[pl_len - 1] : 1'b0, (i == n - 1), bytes[i]});
    endtask

    // driver tasks: all inputs change at posedge + 1
    task automatic send_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
        bit fired;
        int n;
        dest = d; src = s; etype = t; hdr_valid = 1'b1;
        fired = 1'b0; n = 0;
        while (!fired && n < 500) begin
            @(negedge clk);
            fired = hdr_ready;
            @(posedge clk);
            #1;
            n++;
        end
        hdr_valid = 1'b0;
        check("hdr_accept", 32'(fired), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input logic user);
        bit fired;
        int n;
        p_tdata = b; p_tlast = last; p_tuser = user; p_tvalid = 1'b1;
        fired = 1'b0; n = 0;
        while (!fired && n < 2000) begin
            @(negedge clk);
            fired = p_tready;
            @(posedge clk);
            #1;
            n++;
        end
        check("pay_accept", 32'(fired), 32'd1);
    endtask

    task automatic send_payload();
        int g;
        for (int i = 0; i < pl_len; i++) begin
            if (gap_en) begin
                g = $urandom_range(0, 2);
                p_tvalid = 1'b0;
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_byte(pl_data[i], (i == pl_len - 1), pl_user[i]);
        end
        p_tvalid = 1'b0; p_tlast = 1'b0; p_tuser = 1'b0;
    endtask

    // wait for the expected queue to empty; payload side must stay unready
    task automatic wait_drain();
        int n;
        int rdy;
        n = 0; rdy = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            if (p_tready) rdy++;
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("ptready_after_last", 32'(rdy), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        use_pad = v.pad; rmode = v.rmode; gap_en = 1'b0;
        @(posedge clk);
        #1;
        pl_len = v.plen;
        for (int i = 0; i < v.plen; i++) begin
            pl_data[i] = v.first + 8'(17 * i);
            pl_user[i] = (i == v.user_at);
        end
        exp_q.delete();
        model_frame(v.dest, v.src, v.etype, v.pad);
        beats = 0; sb_on = 1'b1;
        send_hdr(v.dest, v.src, v.etype);
        send_payload();
        wait_drain();
        check($sformatf("vec%0d_beats", idx), 32'(beats), 32'(v.exp_beats));
        check($sformatf("vec%0d_last_user", idx), 32'(last_user), 32'(v.exp_user));
        if (v.rmode == 0)
            check($sformatf("vec%0d_span", idx), 32'(last_cyc - first_cyc), 32'(v.exp_beats - 1));
    endtask

    initial begin
        logic [47:0] rd;
        logic [47:0] rs;
        logic [15:0] rt;
        int          exp_n;

        vt[0] = '{48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 8'hAA, 3,  -1, 0, 1'b0, 17, 1'b0};
        vt[1] = '{48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 8'hAA, 3,  -1, 1, 1'b0, 17, 1'b0};
        vt[2] = '{48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 8'hAA, 3,   2, 0, 1'b0, 17, 1'b1};
        vt[3] = '{48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 8'hAA, 3,   1, 0, 1'b0, 17, 1'b0};
        vt[4] = '{48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 8'h55, 1,  -1, 0, 1'b1, 60, 1'b0};
        vt[5] = '{48'hFFFFFFFFFFFF, 48'h020000000001, 16'h86DD, 8'h01, 46, -1, 2, 1'b1, 60, 1'b0};
        vt[6] = '{48'h010203040506, 48'hA1A2A3A4A5A6, 16'h0806, 8'h30, 45, 44, 0, 1'b1, 60, 1'b1};
        vt[7] = '{48'hDEADBEEF0001, 48'hCAFEF00D0002, 16'h88B5, 8'h7E, 1,   0, 1, 1'b0, 15, 1'b1};
        vt[8] = '{48'h00112233AABB, 48'h445566778899, 16'h0800, 8'h80, 70, 69, 2, 1'b1, 84, 1'b1};

        rst = 1'b1; hdr_valid = 1'b0; dest = '0; src = '0; etype = '0;
        p_tdata = '0; p_tvalid = 1'b0; p_tlast = 1'b0; p_tuser = 1'b0; use_pad = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid",  32'({m_tvalid_n, m_tvalid_p}), 32'd0);
        check("rst_tdata",   32'({m_tdata_n, m_tdata_p}), 32'd0);
        check("rst_tlast_tuser", 32'({m_tlast_n, m_tlast_p, m_tuser_n, m_tuser_p}), 32'd0);
        check("rst_busy",    32'({busy_n, busy_p}), 32'd0);
        check("rst_readys",  32'({hdr_ready_n, hdr_ready_p, p_tready_n, p_tready_p}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_hdr_ready", 32'({hdr_ready_n, hdr_ready_p}), 32'd3);
        check("idle_busy0", 32'({busy_n, busy_p}), 32'd0);
        @(posedge clk);
        #1;

        // table-driven frames
        for (int i = 0; i < 9; i++) run_vec(vt[i], i);

        // reset mid-payload aborts the frame without a tlast
        use_pad = 1'b0; rmode = 0; gap_en = 1'b0; sb_on = 1'b0;
        tlast_seen = 0;
        send_hdr(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800);
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(8'hCC, 1'b0, 1'b0);
        p_tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_tvalid", 32'(m_tvalid), 32'd0);
        check("abort_no_tlast", 32'(tlast_seen), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hdr_ready", 32'(hdr_ready), 32'd1);
        @(posedge clk);
        #1;
        exp_q.delete();
        run_vec(vt[0], 9);

        // back-to-back: second header waits for frame 1 tlast
        use_pad = 1'b0; rmode = 0; gap_en = 1'b0;
        @(posedge clk);
        #1;
        pl_len = 3;
        pl_data[0] = 8'hAA; pl_data[1] = 8'hBB; pl_data[2] = 8'hCC;
        pl_user[0] = 1'b0;  pl_user[1] = 1'b0;  pl_user[2] = 1'b0;
        exp_q.delete();
        model_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 1'b0);
        model_frame(48'h665544332211, 48'h0F0E0D0C0B0A, 16'h86DD, 1'b0);
        beats = 0; sb_on = 1'b1; t_last = -1; t_hdr = -1; t_first = -1;
        send_hdr(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800);
        fork
            send_payload();
            begin
                dest = 48'h665544332211; src = 48'h0F0E0D0C0B0A; etype = 16'h86DD;
                hdr_valid = 1'b1; nwait = 0;
                while (t_hdr < 0 && nwait < 500) begin
                    @(negedge clk);
                    if (m_tvalid && m_tlast && t_last < 0) t_last = cyc;
                    if (hdr_ready) t_hdr = cyc;
                    nwait++;
                end
                @(posedge clk);
                #1;
                hdr_valid = 1'b0;
            end
        join
        check("b2b_tlast_seen", 32'(t_last >= 0), 32'd1);
        check("b2b_hdr_ready_cycle", 32'(t_hdr), 32'(t_last));
        nwait = 0;
        while (t_first < 0 && nwait < 50) begin
            @(negedge clk);
            if (m_tvalid) t_first = cyc;
            nwait++;
        end
        check("b2b_gap", 32'((t_first > t_last) && (t_first - t_last <= 2)), 32'd1);
        @(posedge clk);
        #1;
        send_payload();
        wait_drain();
        check("b2b_beats", 32'(beats), 32'd34);

        // randomized frames on both instances
        for (int f = 0; f < 24; f++) begin
            use_pad = 1'($urandom_range(0, 1)); rmode = 2; gap_en = 1'b1;
            @(posedge clk);
            #1;
            rd = {16'($urandom), $urandom};
            rs = {16'($urandom), $urandom};
            rt = 16'($urandom);
            pl_len = $urandom_range(1, 80);
            for (int i = 0; i < pl_len; i++) begin
                pl_data[i] = 8'($urandom);
                pl_user[i] = 1'($urandom_range(0, 1));
            end
            exp_n = 14 + pl_len;
            if (use_pad && exp_n < MIN_LEN) exp_n = MIN_LEN;
            exp_q.delete();
            model_frame(rd, rs, rt, use_pad);
            beats = 0; sb_on = 1'b1;
            send_hdr(rd, rs, rt);
            send_payload();
            wait_drain();
            check($sformatf("rand%0d_beats", f), 32'(beats), 32'(exp_n));
            check($sformatf("rand%0d_last_user", f), 32'(last_user), 32'(pl_user[pl_len - 1]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // global time limit
    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "time limit reached");
    end

endmodule
